// File: rtl/y_mat_row_writer.sv
// Y-matrix row SRAM write side.
// Gathers (index, real, imag) entries into a one-line buffer of 16 lanes and
// issues one masked line write per SRAM line. The line address is index >> LANE_LOG2,
// the same mapping the row reader uses.
module y_mat_row_writer #(
  parameter int unsigned IDX_W     = 16,
  parameter int unsigned LANE_LOG2 = 4,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned ENT_W     = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IDX_W-1:0]              in_idx,
  input  logic [ENT_W-1:0]              in_data,
  input  logic                          flush,
  output logic                          flush_done,
  output logic                          sram_we,
  input  logic                          sram_ready,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [(ENT_W<<LANE_LOG2)-1:0] sram_wdata,
  output logic [(1<<LANE_LOG2)-1:0]     sram_wmask,
  output logic [15:0]                   wr_count,
  output logic                          err_range
);

  localparam int unsigned Lanes = 1 << LANE_LOG2;
  localparam int unsigned LineW = IDX_W - LANE_LOG2;
  localparam int unsigned DataW = ENT_W * Lanes;

  typedef enum logic [0:0] {StEmpty, StFill} buf_state_e;

  // Line buffer
  buf_state_e          stateQ, stateD;
  logic [ADDR_W-1:0]   tagQ, tagD;
  logic [DataW-1:0]    bufDataQ, bufDataD;
  logic [Lanes-1:0]    bufMaskQ, bufMaskD;

  // Output register (OREG) and status
  logic                weQ, weD;
  logic [ADDR_W-1:0]   addrQ, addrD;
  logic [DataW-1:0]    wdataQ, wdataD;
  logic [Lanes-1:0]    wmaskQ, wmaskD;
  logic [15:0]         wrCountQ, wrCountD;
  logic                errRangeQ, errRangeD;

  // Flush bookkeeping; flushWait marks that OREG holds the flushed line
  logic                flushPendQ, flushPendD;
  logic                flushWaitQ, flushWaitD;
  logic                flushDoneQ, flushDoneD;

  // Decoded input entry
  logic [LineW-1:0]     inLine;
  logic [ADDR_W-1:0]    lineAddr;
  logic [LANE_LOG2-1:0] inLane;
  logic [Lanes-1:0]     laneOneHot;
  logic                 inRange;
  logic                 oregFree;
  logic                 accept;
  logic                 accValid;
  logic                 sameLine;
  logic                 evict;
  logic                 lineFull;
  logic                 flushSvc;
  logic                 flushTaken;
  logic [Lanes-1:0]     mergedMask;
  logic [DataW-1:0]     mergedData;

  assign inLine     = in_idx[IDX_W-1:LANE_LOG2];
  assign lineAddr   = ADDR_W'(inLine);
  assign inLane     = in_idx[LANE_LOG2-1:0];
  assign laneOneHot = Lanes'(1) << inLane;
  // Any line bit at or above ADDR_W means the entry has no SRAM home
  assign inRange    = (inLine >> ADDR_W) == '0;

  assign oregFree   = ~weQ | sram_ready;
  assign accept     = in_valid & in_ready;
  assign accValid   = accept & inRange;
  assign sameLine   = (stateQ == StFill) && (tagQ == lineAddr);
  assign evict      = accValid && (stateQ == StFill) && !sameLine;
  assign lineFull   = accValid & (&mergedMask);
  // Accepts take priority; a flush waits for a cycle with no accept
  assign flushSvc   = flushPendQ & oregFree & ~accept & ~flushWaitQ;
  assign flushTaken = flushWaitQ & weQ & sram_ready;

  // Merge the incoming entry into the buffered line (fresh line when not a hit)
  always_comb begin
    mergedMask = (sameLine ? bufMaskQ : '0) | laneOneHot;
    mergedData = sameLine ? bufDataQ : '0;
    mergedData[inLane*ENT_W +: ENT_W] = in_data;
  end

  // Buffer FSM state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      stateQ <= StEmpty;
    end else begin
      stateQ <= stateD;
    end
  end

  // Buffer FSM next state: a completed line or a flush empties it, any kept entry fills it
  always_comb begin
    stateD = stateQ;
    if (accValid) begin
      stateD = lineFull ? StEmpty : StFill;
    end else if (flushSvc && stateQ == StFill) begin
      stateD = StEmpty;
    end
  end

  // Buffer FSM outputs and OREG-facing ports
  always_comb begin
    in_ready   = reset & oregFree;
    flush_done = flushDoneQ;
    sram_we    = weQ;
    sram_addr  = addrQ;
    sram_wdata = wdataQ;
    sram_wmask = wmaskQ;
    wr_count   = wrCountQ;
    err_range  = errRangeQ;
  end

  // Datapath next state: buffer contents, OREG loads, counters and flush tracking
  always_comb begin
    tagD       = tagQ;
    bufDataD   = bufDataQ;
    bufMaskD   = bufMaskQ;
    // A taken write clears sram_we unless a new line is loaded below
    weD        = weQ & ~sram_ready;
    addrD      = addrQ;
    wdataD     = wdataQ;
    wmaskD     = wmaskQ;
    wrCountD   = wrCountQ + ((weQ & sram_ready) ? 16'd1 : 16'd0);
    errRangeD  = errRangeQ | (accept & ~inRange);
    flushPendD = flushPendQ | flush;
    flushWaitD = flushWaitQ;
    flushDoneD = 1'b0;

    if (accValid) begin
      if (evict) begin
        weD    = 1'b1;
        addrD  = tagQ;
        wdataD = bufDataQ;
        wmaskD = bufMaskQ;
      end
      if (lineFull) begin
        weD      = 1'b1;
        addrD    = lineAddr;
        wdataD   = mergedData;
        wmaskD   = mergedMask;
        bufMaskD = '0;
      end else begin
        tagD     = lineAddr;
        bufDataD = mergedData;
        bufMaskD = mergedMask;
      end
    end else if (flushSvc) begin
      if (stateQ == StFill) begin
        weD        = 1'b1;
        addrD      = tagQ;
        wdataD     = bufDataQ;
        wmaskD     = bufMaskQ;
        bufMaskD   = '0;
        flushWaitD = 1'b1;
      end else begin
        flushDoneD = 1'b1;
        flushPendD = flush;
      end
    end

    // Flushed line accepted by the SRAM: report completion next cycle
    if (flushTaken) begin
      flushWaitD = 1'b0;
      flushDoneD = 1'b1;
      flushPendD = flush;
    end
  end

  // Datapath registers; reset drops buffered and pending data
  always_ff @(posedge clock) begin
    if (!reset) begin
      tagQ       <= '0;
      bufDataQ   <= '0;
      bufMaskQ   <= '0;
      weQ        <= 1'b0;
      addrQ      <= '0;
      wdataQ     <= '0;
      wmaskQ     <= '0;
      wrCountQ   <= '0;
      errRangeQ  <= 1'b0;
      flushPendQ <= 1'b0;
      flushWaitQ <= 1'b0;
      flushDoneQ <= 1'b0;
    end else begin
      tagQ       <= tagD;
      bufDataQ   <= bufDataD;
      bufMaskQ   <= bufMaskD;
      weQ        <= weD;
      addrQ      <= addrD;
      wdataQ     <= wdataD;
      wmaskQ     <= wmaskD;
      wrCountQ   <= wrCountD;
      errRangeQ  <= errRangeD;
      flushPendQ <= flushPendD;
      flushWaitQ <= flushWaitD;
      flushDoneQ <= flushDoneD;
    end
  end

endmodule

// File: tb/tb_y_mat_row_writer.sv
// Directed bench for y_mat_row_writer with an expected-write scoreboard.
module tb_y_mat_row_writer;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_idx = '0;
  logic [31:0]  in_data = '0;
  logic         flush = 1'b0;
  logic         flush_done;
  logic         sram_we;
  logic         sram_ready = 1'b1;
  logic [10:0]  sram_addr;
  logic [511:0] sram_wdata;
  logic [15:0]  sram_wmask;
  logic [15:0]  wr_count;
  logic         err_range;

  y_mat_row_writer dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_data    (in_data),
    .flush      (flush),
    .flush_done (flush_done),
    .sram_we    (sram_we),
    .sram_ready (sram_ready),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_wmask (sram_wmask),
    .wr_count   (wr_count),
    .err_range  (err_range)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [10:0]  addr;
    logic [15:0]  mask;
    logic [511:0] data;
  } wr_t;

  wr_t expQ[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  lastTake = -10;
  int  expWr = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [10:0] a, input logic [15:0] m, input logic [511:0] d);
    wr_t e;
    e.addr = a;
    e.mask = m;
    e.data = d;
    expQ.push_back(e);
  endtask

  // Called when a write handshake will complete on the coming edge
  task automatic takeWrite();
    wr_t e;
    checks++;
    assert (expQ.size() > 0) else begin
      errors++;
      $error("FAIL unexpected_write observed addr=0x%0h expected no write", sram_addr);
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      check("wr_addr", 64'(sram_addr), 64'(e.addr));
      check("wr_mask", 64'(sram_wmask), 64'(e.mask));
      for (int k = 0; k < 16; k++) begin
        if (e.mask[k]) begin
          check($sformatf("wr_lane%0d", k), 64'(sram_wdata[k*32 +: 32]),
                64'(e.data[k*32 +: 32]));
        end
      end
    end
    expWr++;
    lastTake = cyc;
  endtask

  task automatic step();
    if (sram_we === 1'b1 && sram_ready === 1'b1) takeWrite();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [15:0] idx, input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_idx   = idx;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
  endtask

  task automatic doFlush(input bit expectWrite);
    int n;
    n = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    while (flush_done !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check("flush_done", 64'(flush_done), 64'(1));
    if (expectWrite) check("flush_done_lat", 64'(cyc - lastTake), 64'(1));
    else             check("flush_empty_lat", 64'(n), 64'(1));
    step();
    check("flush_done_pulse", 64'(flush_done), 64'(0));
  endtask

  initial begin
    logic [511:0] d;

    // Reset state
    repeat (3) step();
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_we", 64'(sram_we), 64'(0));
    check("rst_wr_count", 64'(wr_count), 64'(0));
    check("rst_err", 64'(err_range), 64'(0));
    check("rst_flush_done", 64'(flush_done), 64'(0));
    reset = 1'b1;
    step();
    check("idle_in_ready", 64'(in_ready), 64'(1));

    // 1: full line 2, written one cycle after the 16th accept
    d = '0;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'h20 + k;
    push(11'd2, 16'hFFFF, d);
    for (int k = 0; k < 16; k++) begin
      send(16'h20 + 16'(k), 32'h20 + k);
      if (k == 14) check("t1_we_before_full", 64'(sram_we), 64'(0));
    end
    check("t1_we_after_full", 64'(sram_we), 64'(1));
    step();
    check("t1_wr_count", 64'(wr_count), 64'(1));

    // 2: partial line evicted by a new line, then flushed remainder
    d = '0;
    d[1*32 +: 32] = 32'h31;
    d[5*32 +: 32] = 32'h35;
    push(11'd3, 16'h0022, d);
    d = '0;
    d[0 +: 32] = 32'h40;
    push(11'd4, 16'h0001, d);
    send(16'h0031, 32'h31);
    send(16'h0035, 32'h35);
    check("t2_no_write_yet", 64'(sram_we), 64'(0));
    send(16'h0040, 32'h40);
    check("t2_evict_we", 64'(sram_we), 64'(1));
    doFlush(1'b1);
    check("t2_wr_count", 64'(wr_count), 64'(3));

    // 3: same lane twice, last write wins
    d = '0;
    d[0 +: 32] = 32'hBBBB0002;
    push(11'd5, 16'h0001, d);
    send(16'h0050, 32'hAAAA0001);
    send(16'h0050, 32'hBBBB0002);
    doFlush(1'b1);
    check("t3_wr_count", 64'(wr_count), 64'(4));

    // 4: SRAM stall holds OREG and back-pressures input
    sram_ready = 1'b0;
    d = '0;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'h1000 + k;
    push(11'd6, 16'hFFFF, d);
    for (int k = 0; k < 16; k++) send(16'h60 + 16'(k), 32'h1000 + k);
    in_valid = 1'b1;
    in_idx   = 16'h0070;
    in_data  = 32'h777;
    for (int i = 0; i < 5; i++) begin
      check("t4_in_ready_stall", 64'(in_ready), 64'(0));
      check("t4_we_stall", 64'(sram_we), 64'(1));
      check("t4_addr_stall", 64'(sram_addr), 64'(6));
      check("t4_mask_stall", 64'(sram_wmask), 64'(16'hFFFF));
      check("t4_count_stall", 64'(wr_count), 64'(4));
      step();
    end
    check("t4_lane3_stall", 64'(sram_wdata[3*32 +: 32]), 64'(32'h1003));
    sram_ready = 1'b1;
    d = '0;
    d[0 +: 32] = 32'h777;
    push(11'd7, 16'h0001, d);
    send(16'h0070, 32'h777);
    check("t4_wr_count_release", 64'(wr_count), 64'(5));
    check("t4_we_cleared", 64'(sram_we), 64'(0));
    doFlush(1'b1);
    check("t4_wr_count", 64'(wr_count), 64'(6));

    // 5: out-of-range index is dropped and flagged; empty flush
    send(16'h8000, 32'hDEAD);
    check("t5_err_set", 64'(err_range), 64'(1));
    check("t5_no_write", 64'(sram_we), 64'(0));
    doFlush(1'b0);
    check("t5_err_sticky", 64'(err_range), 64'(1));
    d = '0;
    d[1*32 +: 32] = 32'h91;
    push(11'd9, 16'h0002, d);
    send(16'h0091, 32'h91);
    doFlush(1'b1);
    check("t5_err_still", 64'(err_range), 64'(1));
    check("t5_wr_count", 64'(wr_count), 64'(7));
    check("t5_model_count", 64'(wr_count), 64'(expWr));

    // 6: reset while a write is pending and the buffer is filling
    send(16'h00B0, 32'hB0);
    sram_ready = 1'b0;
    send(16'h00C0, 32'hC0);
    check("t6_we_pending", 64'(sram_we), 64'(1));
    reset = 1'b0;
    step();
    check("t6_we", 64'(sram_we), 64'(0));
    check("t6_addr", 64'(sram_addr), 64'(0));
    check("t6_mask", 64'(sram_wmask), 64'(0));
    check("t6_wdata_any", 64'(|sram_wdata), 64'(0));
    check("t6_wr_count", 64'(wr_count), 64'(0));
    check("t6_err", 64'(err_range), 64'(0));
    check("t6_flush_done", 64'(flush_done), 64'(0));
    check("t6_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b1;
    sram_ready = 1'b1;
    expWr = 0;
    d = '0;
    d[0 +: 32] = 32'h1234;
    push(11'd1, 16'h0001, d);
    send(16'h0010, 32'h1234);
    doFlush(1'b1);
    check("t6_wr_count_after", 64'(wr_count), 64'(1));
    check("end_queue_empty", 64'(expQ.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
